// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I main control FSM:
// opcode constants, ALU control codes, datapath mux encodings and
// the decoded instruction-class / control-bundle structures.
package multicycle_control_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Codes consumed by the ALU control decoder
    localparam logic [1:0] ALU_NOP   = 2'b00;
    localparam logic [1:0] ALU_ADD   = 2'b01;
    localparam logic [1:0] ALU_SUB   = 2'b10;
    localparam logic [1:0] ALU_FUNCT = 2'b11;

    // ALU operand A select
    localparam logic [1:0] SRCA_RS1   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Register-file writeback select
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // One-hot instruction class produced by the opcode decoder
    typedef struct packed {
        logic isOp;
        logic isOpImm;
        logic isLui;
        logic isAuipc;
        logic isLoad;
        logic isStore;
        logic isBranch;
        logic isJal;
        logic isJalr;
    } instClass_t;

    // Complete set of strobes the FSM drives into the datapath
    typedef struct packed {
        logic [1:0] aluCtrl;
        logic       funct7En;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic       memReq;
        logic       memWe;
        logic       iord;
        logic       irWe;
        logic       pcWe;
        logic       pcSrc;
        logic       rfWe;
        logic [1:0] wbSel;
        logic       retire;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode classifier: maps IR[6:0] to a one-hot
// instruction class plus a legal flag for the DECODE dispatch.
module opcode_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] i_opcode,
    output instClass_t o_class,
    output logic       o_legal
);

    // Classify the opcode; anything unrecognised leaves every class bit low
    always_comb begin
        o_class = '0;
        case (i_opcode)
            OPC_OP:     o_class.isOp     = 1'b1;
            OPC_OP_IMM: o_class.isOpImm  = 1'b1;
            OPC_LUI:    o_class.isLui    = 1'b1;
            OPC_AUIPC:  o_class.isAuipc  = 1'b1;
            OPC_LOAD:   o_class.isLoad   = 1'b1;
            OPC_STORE:  o_class.isStore  = 1'b1;
            OPC_BRANCH: o_class.isBranch = 1'b1;
            OPC_JAL:    o_class.isJal    = 1'b1;
            OPC_JALR:   o_class.isJalr   = 1'b1;
            default:    o_class = '0;
        endcase
        o_legal = |o_class;
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core. Sequences each
// instruction through fetch/decode/execute/memory/writeback and drives
// the datapath strobes, the memory-port handshake and alu_ctrl.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_mem_ready,
    input  logic       i_branch_cond,
    output logic [1:0] o_alu_ctrl,
    output logic       o_funct7_en,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_iord,
    output logic       o_ir_we,
    output logic       o_pc_we,
    output logic       o_pc_src,
    output logic       o_rf_we,
    output logic [1:0] o_wb_sel,
    output logic       o_retire,
    output logic       o_illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_U,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM,
        S_BRANCH, S_JAL, S_JALR, S_TRAP
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    instClass_t w_class;
    logic       w_legal;
    ctrl_t      w_ctrl;

    // The controller carries no data; XLEN only documents the core width
    if (XLEN != 32) begin : g_nonStandardXlen
    end

    opcode_decode u_opcodeDecode (
        .i_opcode (i_opcode),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    // State register with synchronous active-low reset back to FETCH
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= S_FETCH;
        else            r_state <= w_nextState;
    end

    // Next-state logic; memory states hold until mem_ready, TRAP is absorbing
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH:    if (i_mem_ready) w_nextState = S_DECODE;
            S_DECODE: begin
                if (!w_legal)                          w_nextState = S_TRAP;
                else if (w_class.isOp)                 w_nextState = S_EXEC_R;
                else if (w_class.isOpImm)              w_nextState = S_EXEC_I;
                else if (w_class.isLui || w_class.isAuipc) w_nextState = S_EXEC_U;
                else if (w_class.isLoad || w_class.isStore) w_nextState = S_MEM_ADDR;
                else if (w_class.isBranch)             w_nextState = S_BRANCH;
                else if (w_class.isJal)                w_nextState = S_JAL;
                else                                   w_nextState = S_JALR;
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_U: w_nextState = S_WB_ALU;
            S_MEM_ADDR: w_nextState = w_class.isStore ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (i_mem_ready) w_nextState = S_WB_MEM;
            S_MEM_WR:   if (i_mem_ready) w_nextState = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR: w_nextState = S_FETCH;
            S_TRAP:     w_nextState = S_TRAP;
            default:    w_nextState = S_TRAP;
        endcase
    end

    // Output decode; everything is forced to zero while reset is asserted
    always_comb begin
        w_ctrl = '0;
        w_ctrl.aluCtrl = ALU_NOP;
        if (i_reset_n) begin
            case (r_state)
                S_FETCH: begin
                    w_ctrl.aluCtrl = ALU_ADD;
                    w_ctrl.aluSrcA = SRCA_PC;
                    w_ctrl.aluSrcB = SRCB_FOUR;
                    w_ctrl.memReq  = 1'b1;
                    w_ctrl.irWe    = i_mem_ready;
                    w_ctrl.pcWe    = i_mem_ready;
                end
                S_DECODE: begin
                    w_ctrl.aluCtrl = ALU_ADD;
                    w_ctrl.aluSrcA = SRCA_OLDPC;
                    w_ctrl.aluSrcB = SRCB_IMM;
                end
                S_EXEC_R: begin
                    w_ctrl.aluCtrl  = ALU_FUNCT;
                    w_ctrl.aluSrcA  = SRCA_RS1;
                    w_ctrl.aluSrcB  = SRCB_RS2;
                    w_ctrl.funct7En = 1'b1;
                end
                S_EXEC_I: begin
                    w_ctrl.aluCtrl  = ALU_FUNCT;
                    w_ctrl.aluSrcA  = SRCA_RS1;
                    w_ctrl.aluSrcB  = SRCB_IMM;
                    w_ctrl.funct7En = (i_funct3 == 3'b101);
                end
                S_EXEC_U: begin
                    w_ctrl.aluCtrl = ALU_ADD;
                    w_ctrl.aluSrcA = w_class.isLui ? SRCA_ZERO : SRCA_OLDPC;
                    w_ctrl.aluSrcB = SRCB_IMM;
                end
                S_MEM_ADDR: begin
                    w_ctrl.aluCtrl = ALU_ADD;
                    w_ctrl.aluSrcA = SRCA_RS1;
                    w_ctrl.aluSrcB = SRCB_IMM;
                end
                S_MEM_RD: begin
                    w_ctrl.memReq = 1'b1;
                    w_ctrl.iord   = 1'b1;
                end
                S_MEM_WR: begin
                    w_ctrl.memReq = 1'b1;
                    w_ctrl.memWe  = 1'b1;
                    w_ctrl.iord   = 1'b1;
                    w_ctrl.retire = i_mem_ready;
                end
                S_WB_ALU: begin
                    w_ctrl.rfWe   = 1'b1;
                    w_ctrl.wbSel  = WB_ALUOUT;
                    w_ctrl.retire = 1'b1;
                end
                S_WB_MEM: begin
                    w_ctrl.rfWe   = 1'b1;
                    w_ctrl.wbSel  = WB_MDR;
                    w_ctrl.retire = 1'b1;
                end
                S_BRANCH: begin
                    w_ctrl.aluCtrl = ALU_SUB;
                    w_ctrl.aluSrcA = SRCA_RS1;
                    w_ctrl.aluSrcB = SRCB_RS2;
                    w_ctrl.pcWe    = i_branch_cond;
                    w_ctrl.pcSrc   = i_branch_cond;
                    w_ctrl.retire  = 1'b1;
                end
                S_JAL: begin
                    w_ctrl.pcWe   = 1'b1;
                    w_ctrl.pcSrc  = 1'b1;
                    w_ctrl.rfWe   = 1'b1;
                    w_ctrl.wbSel  = WB_PC;
                    w_ctrl.retire = 1'b1;
                end
                S_JALR: begin
                    w_ctrl.aluCtrl = ALU_ADD;
                    w_ctrl.aluSrcA = SRCA_RS1;
                    w_ctrl.aluSrcB = SRCB_IMM;
                    w_ctrl.pcWe    = 1'b1;
                    w_ctrl.rfWe    = 1'b1;
                    w_ctrl.wbSel   = WB_PC;
                    w_ctrl.retire  = 1'b1;
                end
                S_TRAP:  w_ctrl.illegal = 1'b1;
                default: w_ctrl.illegal = 1'b1;
            endcase
        end
    end

    assign o_alu_ctrl  = w_ctrl.aluCtrl;
    assign o_funct7_en = w_ctrl.funct7En;
    assign o_alu_src_a = w_ctrl.aluSrcA;
    assign o_alu_src_b = w_ctrl.aluSrcB;
    assign o_mem_req   = w_ctrl.memReq;
    assign o_mem_we    = w_ctrl.memWe;
    assign o_iord      = w_ctrl.iord;
    assign o_ir_we     = w_ctrl.irWe;
    assign o_pc_we     = w_ctrl.pcWe;
    assign o_pc_src    = w_ctrl.pcSrc;
    assign o_rf_we     = w_ctrl.rfWe;
    assign o_wb_sel    = w_ctrl.wbSel;
    assign o_retire    = w_ctrl.retire;
    assign o_illegal   = w_ctrl.illegal;

endmodule
